imem_boot_loader: RTL

//  Boot-time instruction-memory loader that sits directly upstream of the KGP-RISC core.
//  It takes a byte stream (UART RX / test-bench host) through a valid/ready handshake.
//  It packs the bytes into 32-bit instruction words, writes them into instruction memory

---
 rtl/imem_boot_loader.sv | 111 +++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: packs a length-prefixed byte stream into 32-bit words, writes them to
// instruction memory from address 0 and holds the core in reset until the image is complete.
module imem_boot_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {HDR0, HDR1, LOAD, DONE, ERR} LoaderState;

    LoaderState        state;
    LoaderState        nextState;
    logic [7:0]        countHi;
    logic [15:0]       wordCount;
    logic [1:0]        lane;
    logic [23:0]       partial;
    logic              xfer;
    logic [16:0]       fullCount;
    logic [ADDR_W:0]   nextIdx;
    logic              lastWord;

    assign in_ready  = (state == HDR0) || (state == HDR1) || (state == LOAD);
    assign xfer      = in_valid && in_ready;
    assign fullCount = {1'b0, countHi, in_data};
    assign nextIdx   = words_loaded + (ADDR_W+1)'(1);
    // The word being completed is the last one when its index + 1 equals the header count.
    assign lastWord  = (17'(nextIdx) == {1'b0, wordCount});

    always_ff @(posedge clk) begin
        if (rst) state <= HDR0;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            HDR0: if (xfer) nextState = HDR1;
            HDR1: begin
                if (xfer) begin
                    if (fullCount == 17'd0)            nextState = DONE;
                    else if (fullCount > 17'(DEPTH))   nextState = ERR;
                    else                               nextState = LOAD;
                end
            end
            LOAD: if (xfer && lane == 2'd3 && lastWord) nextState = DONE;
            DONE, ERR: if (reload) nextState = HDR0;
            default: nextState = HDR0;
        endcase
    end

    // Datapath: header latch, word assembly, memory write strobe and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            countHi      <= '0;
            wordCount    <= '0;
            lane         <= '0;
            partial      <= '0;
            words_loaded <= '0;
            im_we        <= 1'b0;
            im_addr      <= '0;
            im_wdata     <= '0;
            cpu_rst      <= 1'b1;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            im_we     <= 1'b0;
            cpu_rst   <= (nextState != DONE);
            load_done <= (nextState == DONE);
            load_err  <= (nextState == ERR);
            case (state)
                HDR0: if (xfer) countHi <= in_data;
                HDR1: if (xfer) wordCount <= {countHi, in_data};
                LOAD: begin
                    if (xfer) begin
                        lane <= lane + 2'd1;
                        if (lane == 2'd3) begin
                            im_we        <= 1'b1;
                            im_addr      <= words_loaded[ADDR_W-1:0];
                            im_wdata     <= {partial, in_data};
                            words_loaded <= nextIdx;
                            partial      <= '0;
                        end else begin
                            partial <= {partial[15:0], in_data};
                        end
                    end
                end
                DONE, ERR: begin
                    if (reload) begin
                        words_loaded <= '0;
                        lane         <= '0;
                        partial      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
